uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int TIMEOUT_BITS = 12;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } uart_state_e;

  // Plain-vector copies of the state codes for registers declared as logic.
  localparam logic [1:0] S_IDLE      = ST_IDLE;
  localparam logic [1:0] S_ISSUE     = ST_ISSUE;
  localparam logic [1:0] S_WAIT_DONE = ST_WAIT_DONE;

  function automatic int timeout_cycles(input int clks_per_bit);
    return TIMEOUT_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after last_idx, wrapping.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  int cand;

  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_valid && req[cand]) begin
        pick_valid        = 1'b1;
        pick_idx          = IDX_W'(cand);
        pick_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into one UART
// transmitter. Optional packet lock is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 543
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_lock,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_tx_data_avail,
  output logic [BYTE_W-1:0]         o_tx_data_byte,
  input  logic                      i_tx_active,
  input  logic                      i_tx_done,
  output logic                      o_busy,
  output logic                      o_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LIMIT = timeout_cycles(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

  logic [1:0]         state;
  logic [IDX_W-1:0]   last_winner;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] grant;
  logic [BYTE_W-1:0]  tx_byte;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] cand_req;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               timeout_hit;

`ifdef UART_ARB_LOCK_EN
  logic             lock_active;
  logic [IDX_W-1:0] lock_idx;
  logic             lock_hold;

  // While the owner keeps its lock asserted, nobody else may win.
  assign lock_hold = lock_active && i_req_lock[lock_idx];

  always_comb begin
    cand_req = i_req_valid;
    if (lock_hold) cand_req = i_req_valid & (NUM_REQ'(1) << lock_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else begin
      case (state)
        S_IDLE:      if (lock_active && !i_req_lock[lock_idx]) lock_active <= 1'b0;
        S_ISSUE:     if (i_req_lock[owner]) begin
                       lock_active <= 1'b1;
                       lock_idx    <= owner;
                     end
        S_WAIT_DONE: if (!i_tx_done && timeout_hit) lock_active <= 1'b0;
        default:     lock_active <= 1'b0;
      endcase
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^i_req_lock;
  assign cand_req    = i_req_valid;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req         (cand_req),
    .last_idx    (last_winner),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  assign timeout_hit = (wait_cnt == CNT_MAX);

  // Requester inputs are looked at only in IDLE; stale done pulses elsewhere are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_winner <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      grant       <= '0;
      tx_byte     <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid && !i_tx_active) begin
            owner   <= pick_idx;
            grant   <= pick_onehot;
            tx_byte <= i_req_data[BYTE_W*int'(pick_idx) +: BYTE_W];
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_tx_done || timeout_hit) begin
            last_winner <= owner;
            grant       <= '0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_grant         = grant;
  assign o_tx_data_avail = (state == S_ISSUE);
  assign o_req_ready     = (state == S_ISSUE) ? grant : '0;
  assign o_tx_data_byte  = tx_byte;
  assign o_busy          = (state != S_IDLE);
  assign o_timeout       = (state == S_WAIT_DONE) && !i_tx_done && timeout_hit;

endmodule
